mcu_bus_responder: RTL
======================

Name: mcu_bus_responder

Overview:
Bus-slave end of the multiplexed microcontroller interface (ABUS/DBUS, ALE, CSbar, Rbar, Wbar) that loads the clock chip's configuration.
- Decodes bus cycles synchronously to the system clock.
- Latches the 16-bit address, captures write data and commits it to a 10-entry register bank: B0..B6, operand, hour, minute.
- Register contents drive the datapath directly.
- Read-back onto DBUS is available as an option.

Parameters:
NUM_REGS, 10, number of implemented registers at addresses BASE_ADDR..BASE_ADDR+NUM_REGS-1
BASE_ADDR, 16'h0000, address of B0
DATA_W, 8, register and DBUS width

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
ABUS  input  8  address high byte, valid while ALE=1
dbus_in  input  8  DBUS as seen by chip: address low byte when ALE=1, write data afterwards
dbus_out  output  8  read data; top level drives DBUS with it when dbus_oe=1
dbus_oe  output  1  DBUS output enable
CSbar  input  1  chip select, active low, frames one bus cycle
ALE  input  1  address latch enable, active high
Rbar  input  1  read strobe, active low
Wbar  input  1  write strobe, active low; wins over Rbar when both low
B0..B6  output  8 each  configuration registers 0..6
operand  output  8  register 7
hour  output  8  register 8
minute  output  8  register 9
wr_strobe  output  1  one-cycle pulse on each committed write
wr_index  output  4  register index of last committed write

Behaviour:
- Reset (reset=1 at posedge):
  - State goes to IDLE.
  - All registers 0, dbus_out=0, dbus_oe=0, wr_strobe=0, wr_index=0.
  - An in-progress cycle is abandoned and nothing is committed.
- All inputs are sampled at posedge. No combinational path from bus inputs to outputs.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - CSbar=0 and ALE=1: latch addr={ABUS,dbus_in}, go to ADDR.
  - Any other input combination: stay in IDLE.
- ADDR:
  - CSbar=1: go to IDLE, no commit.
  - ALE=1: re-latch addr.
  - ALE=0: capture shadow=dbus_in and wflag=~Wbar, go to DATA.
- DATA:
  - CSbar=0, ALE=0: update shadow and wflag every cycle, so the last sample before deselect wins.
  - CSbar=0, ALE=1: re-latch addr, discard shadow, go to ADDR.
  - CSbar=1, i.e. commit point:
    - If wflag=1 and BASE_ADDR <= addr < BASE_ADDR+NUM_REGS, then reg[addr-BASE_ADDR] <= shadow, wr_strobe=1 and wr_index=index, all in the same edge.
    - New value visible the cycle after the posedge at which CSbar=1 was sampled.
    - Go to IDLE.
- wr_strobe is high exactly one cycle per commit and 0 otherwise.
- Out-of-range address or wflag=0: no register change, no strobe.
- Addresses are compared at full 16 bits. No aliasing: 16'h0100 is out of range.
- Back-to-back cycles are legal: CSbar may go low again in the cycle immediately after the commit cycle. IDLE accepts ALE on that cycle.
- No value checking on hour/minute: 8-bit value stored verbatim.

Optional Feature:
Macro MCU_BUS_READBACK_EN.
- Defined:
  - In DATA with CSbar=0, Rbar=0, Wbar=1: dbus_oe=1 from the next cycle on, registered.
  - dbus_out = reg[index] for an in-range address, 8'h00 otherwise.
  - dbus_oe drops to 0 the cycle after CSbar=1, Wbar=0 or ALE=1 is sampled.
  - Reads never change registers or pulse wr_strobe.
- Undefined: dbus_oe and dbus_out are tied 0; the read path is absent.

Test Plan:
1. Reset then write addr 16'h0001 data 89 (3-clock cycle: ALE high 1 clk, data 1 clk, CSbar release) -> B1=8'h59 one clock after CSbar=1 sampled; wr_strobe one cycle, wr_index=1; all other regs 0.
2. Write sequence B0..B6=13,89,73,59,23,67,1, operand=8'hED, hour=23, minute=33 back-to-back -> all ten outputs hold these values; exactly 10 wr_strobe pulses.
3. Write addr 16'h000A data 8'h55 and addr 16'h0107 data 8'h55 -> no register change, no wr_strobe.
4. Start write to addr 8, re-assert ALE with addr 9 mid-DATA, data 42 -> minute=42, hour unchanged.
5. Assert reset during DATA phase of write to addr 7 -> operand stays 0, no wr_strobe, next normal cycle commits correctly.
6. MCU_BUS_READBACK_EN defined: after test 2, read addr 8 (Wbar=1, Rbar=0) -> dbus_oe=1, dbus_out=8'd23; read addr 16'h0020 -> dbus_out=0; undefined: dbus_oe stays 0 throughout.

Source files
------------

// File: rtl/mcu_bus_responder.sv
// rtl/mcu_bus_responder.sv - bus-slave register bank for the multiplexed MCU configuration interface
//
// Decodes ALE/CSbar/Rbar/Wbar bus cycles on the rising edge of clock, latches the
// 16-bit address {ABUS, dbus_in}, and commits the last sampled write data to one
// of NUM_REGS registers when CSbar is released.
// Optional read-back onto DBUS is built when MCU_BUS_READBACK_EN is defined.
//
// Ports:
//   clock, reset        - system clock, synchronous active-high reset
//   ABUS, dbus_in       - address high byte / multiplexed address low byte and data
//   CSbar, ALE          - cycle framing and address latch enable
//   Rbar, Wbar          - read and write strobes, active low (Wbar wins)
//   dbus_out, dbus_oe   - registered read data and DBUS output enable
//   B0..B6, operand,
//   hour, minute        - register contents, driven directly from the bank
//   wr_strobe, wr_index - one-cycle commit pulse and index of the last commit
module mcu_bus_responder #(
    parameter int          NUM_REGS  = 10,
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int          DATA_W    = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        ABUS,
    input  logic [DATA_W-1:0] dbus_in,
    output logic [DATA_W-1:0] dbus_out,
    output logic              dbus_oe,
    input  logic              CSbar,
    input  logic              ALE,
    input  logic              Rbar,
    input  logic              Wbar,
    output logic [DATA_W-1:0] B0,
    output logic [DATA_W-1:0] B1,
    output logic [DATA_W-1:0] B2,
    output logic [DATA_W-1:0] B3,
    output logic [DATA_W-1:0] B4,
    output logic [DATA_W-1:0] B5,
    output logic [DATA_W-1:0] B6,
    output logic [DATA_W-1:0] operand,
    output logic [DATA_W-1:0] hour,
    output logic [DATA_W-1:0] minute,
    output logic              wr_strobe,
    output logic [3:0]        wr_index
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    // The bank always holds at least the ten named registers.
    localparam int ARR = (NUM_REGS > 10) ? NUM_REGS : 10;

    logic [1:0]        state_q, state_d;
    logic [15:0]       addr_q, addr_d;
    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic              wflag_q, wflag_d;
    logic              wr_strobe_q, wr_strobe_d;
    logic [3:0]        wr_index_q, wr_index_d;
    logic [DATA_W-1:0] regs_q [ARR];
    logic [DATA_W-1:0] regs_d [ARR];

    // Full 16-bit range check: a 17-bit difference catches addresses below BASE_ADDR,
    // so nothing aliases into the bank.
    logic [16:0] diff;
    logic [3:0]  idx;
    logic        in_range;
    logic        commit;

    assign diff     = {1'b0, addr_q} - {1'b0, BASE_ADDR};
    assign idx      = diff[3:0];
    assign in_range = !diff[16] && (diff[15:0] < 16'(NUM_REGS));

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        shadow_d    = shadow_q;
        wflag_d     = wflag_q;
        commit      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!CSbar && ALE) begin
                    addr_d  = {ABUS, dbus_in};
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (CSbar) begin
                    state_d = ST_IDLE;
                end else if (ALE) begin
                    addr_d = {ABUS, dbus_in};
                end else begin
                    shadow_d = dbus_in;
                    wflag_d  = ~Wbar;
                    state_d  = ST_DATA;
                end
            end
            ST_DATA: begin
                if (CSbar) begin
                    commit  = wflag_q && in_range;
                    state_d = ST_IDLE;
                end else if (ALE) begin
                    // New address phase inside the same select: drop pending data.
                    addr_d   = {ABUS, dbus_in};
                    shadow_d = '0;
                    wflag_d  = 1'b0;
                    state_d  = ST_ADDR;
                end else begin
                    shadow_d = dbus_in;
                    wflag_d  = ~Wbar;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        regs_d      = regs_q;
        wr_strobe_d = commit;
        wr_index_d  = wr_index_q;
        if (commit) begin
            regs_d[idx] = shadow_q;
            wr_index_d  = idx;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            shadow_q    <= '0;
            wflag_q     <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_index_q  <= '0;
            for (int i = 0; i < ARR; i++) regs_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            shadow_q    <= shadow_d;
            wflag_q     <= wflag_d;
            wr_strobe_q <= wr_strobe_d;
            wr_index_q  <= wr_index_d;
            regs_q      <= regs_d;
        end
    end

`ifdef MCU_BUS_READBACK_EN
    logic              oe_q, oe_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    always_comb begin
        oe_d = oe_q;
        if (state_q == ST_DATA && !CSbar && !ALE && !Rbar && Wbar) begin
            oe_d = 1'b1;
        end else if (CSbar || !Wbar || ALE) begin
            oe_d = 1'b0;
        end
        rdata_d = (oe_d && in_range) ? regs_q[idx] : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            oe_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            oe_q    <= oe_d;
            rdata_q <= rdata_d;
        end
    end

    assign dbus_oe  = oe_q;
    assign dbus_out = rdata_q;
`else
    logic unused_rbar;
    assign unused_rbar = Rbar;
    assign dbus_oe     = 1'b0;
    assign dbus_out    = '0;
`endif

    assign B0        = regs_q[0];
    assign B1        = regs_q[1];
    assign B2        = regs_q[2];
    assign B3        = regs_q[3];
    assign B4        = regs_q[4];
    assign B5        = regs_q[5];
    assign B6        = regs_q[6];
    assign operand   = regs_q[7];
    assign hour      = regs_q[8];
    assign minute    = regs_q[9];
    assign wr_strobe = wr_strobe_q;
    assign wr_index  = wr_index_q;

endmodule
